multi_channel_clock_divider: RTL and testbench

Parametrised, multi-channel successor to the single fixed 1 Hz divider. It turns the 100 MHz board clock into CHANNELS independent, runtime-programmable timebases. Each channel can produce a square wave, a periodic one-cycle tick, or a one-shot tick. It feeds the game timer, display refresh and input-debounce logic, and all outputs are synchronous to CLK100M; none are used as clocks.

---
 rtl/timer_pkg.sv | 18 +
 rtl/timer_channel.sv | 120 ++++++++++++
 rtl/multi_channel_clock_divider.sv | 44 ++++
 tb/tb_multi_channel_clock_divider.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the multi-channel timebase: mode encoding, default width and divisor.
package timer_pkg;

  localparam int TIMER_WIDTH = 28;
  localparam logic [27:0] DEFAULT_DIV = 28'd50_000_000;

  typedef enum logic [1:0] {
    MODE_SQUARE  = 2'b00,
    MODE_TICK    = 2'b01,
    MODE_ONESHOT = 2'b10
  } mode_e;

  // Encoding 11 has no meaning of its own and behaves as a periodic tick.
  function automatic mode_e norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_TICK : mode_e'(m);
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One divider channel: counter, active/pending configuration and registered tick/wave/done.
module timer_channel
  import timer_pkg::*;
#(
  parameter int                WIDTH   = TIMER_WIDTH,
  parameter logic [WIDTH-1:0]  RST_DIV = WIDTH'(DEFAULT_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sync_clr_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] wdiv_i,
  input  logic [1:0]       wmode_i,
  output logic             tick_o,
  output logic             wave_o,
  output logic             done_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d, div_q, div_d, pdiv_q, pdiv_d;
  mode_e            mode_q, mode_d, pmode_q, pmode_d;
  logic             pend_q, pend_d, en_q;
  logic             tick_q, tick_d, wave_q, wave_d, done_q, done_d;
  logic             boundary;
  mode_e            wmode;

  assign wmode = norm_mode(wmode_i);

  always_comb begin
    cnt_d    = cnt_q;
    div_d    = div_q;
    mode_d   = mode_q;
    pdiv_d   = pdiv_q;
    pmode_d  = pmode_q;
    pend_d   = pend_q;
    tick_d   = 1'b0;
    wave_d   = wave_q;
    done_d   = done_q;
    boundary = 1'b0;
    if (!en_i || !en_q || sync_clr_i) begin
      // Not running (disabled, start edge or phase restart): everything
      // restarts from zero and configuration lands in the active set now.
      cnt_d  = '0;
      wave_d = 1'b0;
      done_d = 1'b0;
      pend_d = 1'b0;
      if (pend_q) begin
        div_d  = pdiv_q;
        mode_d = pmode_q;
      end
      if (we_i) begin
        div_d  = wdiv_i;
        mode_d = wmode;
      end
    end else begin
      boundary = (div_q != '0) && !done_q && (cnt_q == div_q - ONE);
      if (boundary) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        if (mode_q == MODE_SQUARE)  wave_d = ~wave_q;
        if (mode_q == MODE_ONESHOT) done_d = 1'b1;
        if (pend_q) begin
          div_d  = pdiv_q;
          mode_d = pmode_q;
          pend_d = 1'b0;
        end
      end else if (div_q != '0 && !done_q) begin
        cnt_d = cnt_q + ONE;
      end
      if (we_i) begin
        if (done_q) begin
          // A finished one-shot has no boundary left, so a write re-arms it directly.
          div_d  = wdiv_i;
          mode_d = wmode;
          pend_d = 1'b0;
          done_d = 1'b0;
          cnt_d  = '0;
        end else begin
          pdiv_d  = wdiv_i;
          pmode_d = wmode;
          pend_d  = 1'b1;
        end
      end
    end
    if (mode_d != MODE_SQUARE) wave_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      div_q   <= RST_DIV;
      mode_q  <= MODE_SQUARE;
      pdiv_q  <= '0;
      pmode_q <= MODE_SQUARE;
      pend_q  <= 1'b0;
      en_q    <= 1'b0;
      tick_q  <= 1'b0;
      wave_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
      pdiv_q  <= pdiv_d;
      pmode_q <= pmode_d;
      pend_q  <= pend_d;
      en_q    <= en_i;
      tick_q  <= tick_d;
      wave_q  <= wave_d;
      done_q  <= done_d;
    end
  end

  assign tick_o = tick_q;
  assign wave_o = wave_q;
  assign done_o = done_q;

endmodule

// File: rtl/multi_channel_clock_divider.sv
// CHANNELS independent programmable timebases from the 100 MHz clock; decodes config writes per channel.
module multi_channel_clock_divider #(
  parameter int               CHANNELS    = 4,
  parameter int               WIDTH       = timer_pkg::TIMER_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(timer_pkg::DEFAULT_DIV),
  localparam int              CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK100M,
  input  logic                RST_N,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic                sync_clr,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic [1:0]          cfg_mode,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] wave,
  output logic [CHANNELS-1:0] done
);

  logic [CHANNELS-1:0] ch_we;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    // Addresses at or beyond CHANNELS match no instance and are dropped.
    assign ch_we[g] = cfg_we && (int'(cfg_ch) == g);

    timer_channel #(
      .WIDTH   (WIDTH),
      .RST_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk        (CLK100M),
      .rst_n      (RST_N),
      .en_i       (ch_en[g]),
      .sync_clr_i (sync_clr),
      .we_i       (ch_we[g]),
      .wdiv_i     (cfg_div),
      .wmode_i    (cfg_mode),
      .tick_o     (tick[g]),
      .wave_o     (wave[g]),
      .done_o     (done[g])
    );
  end

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Directed bench for multi_channel_clock_divider with a reduced default divisor of 10.
module tb_multi_channel_clock_divider;

  localparam int CH = 5;
  localparam int W  = 28;

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] ch_en;
  logic          sync_clr;
  logic          cfg_we;
  logic [2:0]    cfg_ch;
  logic [W-1:0]  cfg_div;
  logic [1:0]    cfg_mode;
  logic [CH-1:0] tick, wave, done;

  int n_cmp = 0;
  int n_err = 0;

  multi_channel_clock_divider #(
    .CHANNELS    (CH),
    .WIDTH       (W),
    .DEFAULT_DIV (28'd10)
  ) dut (
    .CLK100M  (clk),
    .RST_N    (rst_n),
    .ch_en    (ch_en),
    .sync_clr (sync_clr),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_mode (cfg_mode),
    .tick     (tick),
    .wave     (wave),
    .done     (done)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [2:0] ch, input logic [W-1:0] dv, input logic [1:0] md);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_div  = dv;
    cfg_mode = md;
  endtask

  // Checker
  task automatic chk(input string tag, input int k, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; ch_en = '0; sync_clr = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = '0;
    cyc(); cyc();
    chk("rst_tick", 0, |tick, 1'b0);
    chk("rst_wave", 0, |wave, 1'b0);
    chk("rst_done", 0, |done, 1'b0);
    rst_n = 1'b1;
    cyc();

    // ch0 at default divisor 10, square wave; reset asserted mid-period
    ch_en[0] = 1'b1;
    cyc();
    for (int k = 1; k <= 15; k++) begin
      cyc();
      chk("ch0_tick", k, tick[0], (k % 10) == 0);
      chk("ch0_wave", k, wave[0], ((k / 10) % 2) == 1);
    end
    rst_n = 1'b0;
    #1;
    chk("async_rst_wave", 0, |wave, 1'b0);
    chk("async_rst_tick", 0, |tick, 1'b0);
    cyc();
    ch_en = '0;
    rst_n = 1'b1;
    cyc();
    chk("post_rst_wave", 0, |wave, 1'b0);

    // ch1 periodic tick div 4, out-of-range write, then pending write to div 2 at counter 1
    cfg(3'd1, 28'd4, 2'b01);
    cyc();
    cfg_we = 1'b0;
    ch_en[1] = 1'b1;
    cyc();
    for (int k = 1; k <= 22; k++) begin
      cyc();
      chk("ch1_tick", k, tick[1], (k <= 16) ? ((k % 4) == 0) : ((k % 2) == 0));
      chk("ch1_wave", k, wave[1], 1'b0);
      cfg_we = 1'b0;
      if (k == 5)  cfg(3'd7, 28'd1, 2'b00);
      if (k == 13) cfg(3'd1, 28'd2, 2'b01);
    end
    ch_en[1] = 1'b0;

    // ch2 square div 3, then div 1
    cfg(3'd2, 28'd3, 2'b00);
    cyc();
    cfg_we = 1'b0;
    ch_en[2] = 1'b1;
    cyc();
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk("ch2_wave", k, wave[2], ((k / 3) % 2) == 1);
      chk("ch2_tick", k, tick[2], (k % 3) == 0);
    end
    ch_en[2] = 1'b0;
    cfg(3'd2, 28'd1, 2'b00);
    cyc();
    cfg_we = 1'b0;
    ch_en[2] = 1'b1;
    cyc();
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk("ch2_div1_wave", k, wave[2], (k % 2) == 1);
      chk("ch2_div1_tick", k, tick[2], 1'b1);
    end
    ch_en[2] = 1'b0;

    // ch3 one-shot div 5
    cfg(3'd3, 28'd5, 2'b10);
    cyc();
    cfg_we = 1'b0;
    ch_en[3] = 1'b1;
    cyc();
    for (int k = 1; k <= 25; k++) begin
      cyc();
      chk("ch3_tick", k, tick[3], k == 5);
      chk("ch3_done", k, done[3], k >= 5);
    end
    ch_en[3] = 1'b0;
    cyc();
    chk("ch3_done_clr", 0, done[3], 1'b0);

    // ch0/ch1 div 6 with offset phase; sync_clr lands on ch0's boundary
    cfg(3'd0, 28'd6, 2'b01);
    cyc();
    cfg(3'd1, 28'd6, 2'b01);
    cyc();
    cfg_we = 1'b0;
    ch_en[0] = 1'b1;
    cyc();
    cyc();
    ch_en[1] = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    sync_clr = 1'b1;
    cyc();
    sync_clr = 1'b0;
    chk("sync_tick0", 0, tick[0], 1'b0);
    chk("sync_tick1", 0, tick[1], 1'b0);
    for (int k = 1; k <= 7; k++) begin
      cyc();
      chk("sync_ch0", k, tick[0], k == 6);
      chk("sync_ch1", k, tick[1], k == 6);
    end
    ch_en = '0;

    // div 0 written to disabled ch4, then enabled: idle
    cfg(3'd4, 28'd0, 2'b01);
    cyc();
    cfg_we = 1'b0;
    ch_en[4] = 1'b1;
    cyc();
    for (int k = 1; k <= 50; k++) begin
      cyc();
      chk("ch4_div0_tick", k, tick[4], 1'b0);
    end
    chk("ch4_div0_done", 0, done[4], 1'b0);
    ch_en = '0;

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
